// File: rtl/pwm_dac_pkg.sv
// Shared definitions for the multi-channel PWM DAC: mode and direction
// encodings plus the full-scale duty helper.
package pwm_dac_pkg;

  typedef enum logic {EDGE = 1'b0, CENTER = 1'b1} mode_e;
  typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_e;

  function automatic int unsigned pwm_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/pwm_dac_chan.sv
// One PWM channel: shadow/active duty pair, comparator against the shared
// counter, and the registered output.
module pwm_dac_chan
  import pwm_dac_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_enable,
  input  logic             i_bound,
  input  logic             i_mode,
  input  logic [WIDTH-1:0] i_cnt,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic             o_pwm
);

  localparam logic [WIDTH-1:0] FULL = WIDTH'(pwm_max(WIDTH));

  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] r_active;
  logic             r_pwm;
  logic [WIDTH-1:0] w_duty;
  logic             w_hit;

  // On the boundary cycle the comparator already sees the committing shadow
  // value, so the first cycle of a period never uses the stale duty.
  always_comb begin
    w_duty = i_bound ? r_shadow : r_active;
    if (mode_e'(i_mode) == CENTER) w_hit = (i_cnt >= (FULL - w_duty));
    else                           w_hit = (i_cnt < w_duty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_active <= '0;
      r_pwm    <= 1'b0;
    end else begin
      if (i_wr)    r_shadow <= i_wr_data;
      if (i_bound) r_active <= r_shadow;
      r_pwm <= i_enable & w_hit;
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/pwm_dac_mc.sv
// Multi-channel PWM DAC: shared edge/center-aligned counter, period boundary
// detection with atomic duty/mode commit, and write decode to the channels.
module pwm_dac_mc
  import pwm_dac_pkg::*;
#(
  parameter  int unsigned WIDTH    = 8,
  parameter  int unsigned CHANNELS = 4,
  localparam int unsigned CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                center_mode,
  input  logic                wr_en,
  input  logic [CHW-1:0]      wr_ch,
  input  logic [WIDTH-1:0]    wr_data,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_start
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(pwm_max(WIDTH) - 1);

  logic [WIDTH-1:0] r_cnt;
  dir_e             r_dir;
  mode_e            r_mode;
  logic             r_restart;
  logic             r_ps;

  logic [WIDTH-1:0] w_cnt;
  dir_e             w_dir;
  mode_e            w_mode;
  logic             w_bound;
  logic [WIDTH-1:0] w_cnt_nxt;
  dir_e             w_dir_nxt;

  // The frozen count is kept while disabled; r_restart makes the first
  // enabled cycle behave as cnt=0/up without rewriting the frozen value.
  always_comb begin
    w_cnt     = r_restart ? '0 : r_cnt;
    w_dir     = r_restart ? UP : r_dir;
    w_bound   = enable && (w_cnt == '0) && (w_dir == UP);
    w_mode    = w_bound ? mode_e'(center_mode) : r_mode;
    w_cnt_nxt = r_cnt;
    w_dir_nxt = r_dir;
    if (enable) begin
      if (w_mode == EDGE) begin
        w_dir_nxt = UP;
        w_cnt_nxt = (w_cnt == LAST) ? '0 : w_cnt + 1'b1;
      end else if (w_dir == UP) begin
        w_cnt_nxt = (w_cnt == LAST) ? w_cnt : w_cnt + 1'b1;
        w_dir_nxt = (w_cnt == LAST) ? DOWN : UP;
      end else begin
        w_cnt_nxt = (w_cnt == '0) ? w_cnt : w_cnt - 1'b1;
        w_dir_nxt = (w_cnt == '0) ? UP : DOWN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_dir     <= UP;
      r_mode    <= EDGE;
      r_restart <= 1'b0;
      r_ps      <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_dir     <= w_dir_nxt;
      r_mode    <= w_mode;
      r_restart <= !enable;
      r_ps      <= w_bound;
    end
  end

  assign period_start = r_ps;

  for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_chan
    localparam logic [CHW-1:0] IDX = CHW'(g);
    logic w_wr;
    assign w_wr = wr_en && (wr_ch == IDX);

    pwm_dac_chan #(.WIDTH(WIDTH)) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_enable  (enable),
      .i_bound   (w_bound),
      .i_mode    (w_mode),
      .i_cnt     (w_cnt),
      .i_wr      (w_wr),
      .i_wr_data (wr_data),
      .o_pwm     (pwm_out[g])
    );
  end

endmodule

// File: tb/tb_pwm_dac_mc.sv
// Directed bench for pwm_dac_mc: 8-bit/4-channel table plus multi-cycle
// corner sequences, and a 4-bit/1-channel instance checked in parallel.
module tb_pwm_dac_mc;

  logic       clk = 1'b0;
  logic       rst_n, enable, center_mode, wr_en;
  logic [1:0] wr_ch;
  logic [7:0] wr_data;
  logic [3:0] pwm_out;
  logic       period_start;

  logic       s_rst_n, s_en, s_center, s_wr_en, s_wr_ch;
  logic [3:0] s_wr_data;
  logic [0:0] s_pwm;
  logic       s_ps;
  logic       s_done = 1'b0;

  int n_err = 0;
  int n_chk = 0;
  int m_hi[4];
  int m_len, m_f0, m_l0;

  always #5 clk = ~clk;

  pwm_dac_mc #(.WIDTH(8), .CHANNELS(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .center_mode(center_mode),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
    .pwm_out(pwm_out), .period_start(period_start)
  );

  pwm_dac_mc #(.WIDTH(4), .CHANNELS(1)) dut_s (
    .clk(clk), .rst_n(s_rst_n), .enable(s_en), .center_mode(s_center),
    .wr_en(s_wr_en), .wr_ch(s_wr_ch), .wr_data(s_wr_data),
    .pwm_out(s_pwm), .period_start(s_ps)
  );

  task automatic check(input string name, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic wr(input int ch, input int val);
    wr_en = 1'b1; wr_ch = 2'(ch); wr_data = 8'(val);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_ps();
    int n = 0;
    do begin @(negedge clk); n++; end while (!period_start && n < 700);
    if (!period_start) check("ps_timeout", 0, 1);
  endtask

  // Starts on a negedge where period_start is seen; ends on the next one.
  task automatic measure();
    m_hi = '{default: 0}; m_len = 0; m_f0 = -1; m_l0 = -1;
    forever begin
      for (int c = 0; c < 4; c++) if (pwm_out[c]) m_hi[c]++;
      if (pwm_out[0]) begin if (m_f0 < 0) m_f0 = m_len; m_l0 = m_len; end
      m_len++;
      @(negedge clk);
      if (period_start) break;
      if (m_len > 700) begin check("period_timeout", 0, 1); break; end
    end
  endtask

  task automatic edge_period(input int kw1, input int d1, input int kw2, input int d2,
                             input int km, input int ch, output int hi);
    hi = 0;
    for (int k = 0; k < 255; k++) begin
      if (k > 0) @(negedge clk);
      if (pwm_out[ch]) hi++;
      wr_en   = (k == kw1) || (k == kw2);
      wr_ch   = 2'(ch);
      wr_data = (k == kw2) ? 8'(d2) : 8'(d1);
      if (k == km) center_mode = 1'b1;
    end
    @(negedge clk);
    wr_en = 1'b0;
    check("edge_period_len", int'(period_start), 1);
  endtask

  typedef struct {
    logic           mode;
    logic [3:0][7:0] duty;
    logic [3:0][9:0] exp_hi;
    int             exp_len;
    int             exp_f0;
    int             exp_l0;
  } vec_t;

  typedef struct {
    logic       mode;
    logic [3:0] duty;
    int         hi;
    int         len;
  } svec_t;

  initial begin
    vec_t vecs[4];
    int hi, bad, first_ps;
    vecs[0] = '{mode:1'b0, duty:{8'd255, 8'd100, 8'd20, 8'd0},
                exp_hi:{10'd255, 10'd100, 10'd20, 10'd0}, exp_len:255, exp_f0:-1, exp_l0:-1};
    vecs[1] = '{mode:1'b1, duty:{8'd37, 8'd255, 8'd0, 8'd100},
                exp_hi:{10'd74, 10'd510, 10'd0, 10'd200}, exp_len:510, exp_f0:155, exp_l0:354};
    vecs[2] = '{mode:1'b0, duty:{8'd7, 8'd128, 8'd254, 8'd1},
                exp_hi:{10'd7, 10'd128, 10'd254, 10'd1}, exp_len:255, exp_f0:0, exp_l0:0};
    vecs[3] = '{mode:1'b1, duty:{8'd0, 8'd128, 8'd1, 8'd255},
                exp_hi:{10'd0, 10'd256, 10'd2, 10'd510}, exp_len:510, exp_f0:0, exp_l0:509};

    rst_n = 1'b0; enable = 1'b0; center_mode = 1'b0;
    wr_en = 1'b0; wr_ch = '0; wr_data = '0;
    #12;
    check("reset_pwm", int'(pwm_out), 0);
    check("reset_ps", int'(period_start), 0);
    @(negedge clk);
    rst_n = 1'b1; enable = 1'b1;

    for (int v = 0; v < 4; v++) begin
      center_mode = vecs[v].mode;
      for (int c = 0; c < 4; c++) wr(c, int'(vecs[v].duty[c]));
      wait_ps(); wait_ps();
      measure();
      for (int c = 0; c < 4; c++)
        check($sformatf("v%0d_hi_ch%0d", v, c), m_hi[c], int'(vecs[v].exp_hi[c]));
      check($sformatf("v%0d_len", v), m_len, vecs[v].exp_len);
      check($sformatf("v%0d_first_ch0", v), m_f0, vecs[v].exp_f0);
      check($sformatf("v%0d_last_ch0", v), m_l0, vecs[v].exp_l0);
    end

    // Shadow write mid-period and on the boundary cycle itself.
    center_mode = 1'b0;
    wr(1, 60);
    wait_ps(); wait_ps();
    edge_period(100, 150, 254, 200, -1, 1, hi);
    check("shadow_cur_period", hi, 60);
    measure();
    check("shadow_next_150", m_hi[1], 150);
    check("shadow_next_len", m_len, 255);
    measure();
    check("shadow_after_200", m_hi[1], 200);

    // Mode toggle mid-period takes effect only at the next boundary.
    wr(0, 100);
    wait_ps(); wait_ps();
    edge_period(-1, 0, -1, 0, 50, 0, hi);
    check("mode_cur_edge_hi", hi, 100);
    measure();
    check("mode_next_len", m_len, 510);
    check("mode_next_hi", m_hi[0], 200);
    check("mode_next_first", m_f0, 155);
    check("mode_next_last", m_l0, 354);

    // Enable low for 37 cycles mid-period.
    center_mode = 1'b0;
    wait_ps(); wait_ps();
    bad = 0;
    for (int k = 0; k <= 88; k++) begin
      if (k > 0) @(negedge clk);
      if (k >= 51 && k <= 87 && (pwm_out != 4'b0 || period_start)) bad++;
      if (k == 50) enable = 1'b0;
      if (k == 87) enable = 1'b1;
    end
    check("disabled_outputs_zero", bad, 0);
    check("restart_ps", int'(period_start), 1);
    check("restart_pwm", int'(pwm_out), 4'b0111);
    measure();
    check("restart_len", m_len, 255);
    check("restart_hi_ch0", m_hi[0], 100);

    // Asynchronous reset pulse between edges with duty 255 active.
    wr(3, 255);
    wait_ps(); wait_ps();
    check("pre_reset_ch3", int'(pwm_out[3]), 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("async_reset_pwm", int'(pwm_out), 0);
    #2 rst_n = 1'b1;
    bad = 0; first_ps = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (pwm_out != 4'b0) bad++;
      if (period_start && first_ps < 0) first_ps = k;
    end
    check("post_reset_quiet", bad, 0);
    check("post_reset_first_ps", first_ps, 1);
    wr(3, 255); wr(0, 20);
    wait_ps(); wait_ps();
    measure();
    check("post_reset_hi_ch3", m_hi[3], 255);
    check("post_reset_hi_ch0", m_hi[0], 20);

    wait (s_done);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    svec_t sv[6];
    int hi, len, n;
    sv[0] = '{1'b0, 4'd5, 5, 15};
    sv[1] = '{1'b1, 4'd5, 10, 30};
    sv[2] = '{1'b0, 4'd15, 15, 15};
    sv[3] = '{1'b1, 4'd0, 0, 30};
    sv[4] = '{1'b1, 4'd15, 30, 30};
    sv[5] = '{1'b0, 4'd1, 1, 15};

    s_rst_n = 1'b0; s_en = 1'b0; s_center = 1'b0;
    s_wr_en = 1'b0; s_wr_ch = 1'b0; s_wr_data = '0;
    #12;
    check("s_reset_pwm", int'(s_pwm), 0);
    check("s_reset_ps", int'(s_ps), 0);
    @(negedge clk);
    s_rst_n = 1'b1; s_en = 1'b1;

    for (int v = 0; v < 6; v++) begin
      s_center = sv[v].mode;
      s_wr_en = 1'b1; s_wr_ch = 1'b0; s_wr_data = sv[v].duty;
      @(negedge clk);
      s_wr_ch = 1'b1; s_wr_data = 4'd9;
      @(negedge clk);
      s_wr_en = 1'b0;
      for (int r = 0; r < 2; r++) begin
        n = 0;
        do begin @(negedge clk); n++; end while (!s_ps && n < 100);
        if (!s_ps) check("s_ps_timeout", 0, 1);
      end
      hi = 0; len = 0;
      do begin
        if (s_pwm[0]) hi++;
        len++;
        @(negedge clk);
      end while (!s_ps && len < 100);
      check($sformatf("s_v%0d_hi", v), hi, sv[v].hi);
      check($sformatf("s_v%0d_len", v), len, sv[v].len);
    end
    s_done = 1'b1;
  end

endmodule
